pcie_phy_init_seq: RTL and testbench
====================================

Name: pcie_phy_init_seq

Overview:
- RTL replacement for the hand-written PHY bring-up sequence used by the PCIe EP/RP benches. One instance per PHY (EP, RP).
- On `start`, issues one APB write of an init word to the PHY. It then waits for the PHY microcontroller to report init complete, counts a settle delay, and releases both PHY resets.
- After init, it arbitrates the single PHY APB port to a host pass-through requester.

Parameters:
- AWIDTH, 18, APB address width.
- DWIDTH, 32, APB data width.
- INIT_ADDR, 18'h3_0068, init register address.
- INIT_DATA, 32'h1000_0000, init register data.
- RST_DLY, 20, clk cycles from uc_init_complete to reset release; legal range 1..255.
- UC_TIMEOUT, 65535, maximum cycles to wait for uc_init_complete; legal range 1..65535.

Ports:
- clk  in  1  PHY APB / core clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins init; honoured only in IDLE.
- uc_init_complete  in  1  PHY microcontroller init done (level).
- phy_reset_n  out  1  PHY main reset, active low.
- phy_p00_reset_n  out  1  PHY lane-0 reset, active low.
- init_done  out  1  high in DONE.
- init_err  out  1  sticky error flag; cleared only by rst.
- seq_state  out  3  current state encoding, for debug.
- apb_paddr  out  AWIDTH  APB master address.
- apb_pwdata  out  DWIDTH  APB master write data.
- apb_pwrite  out  1  APB master write enable.
- apb_psel  out  1  APB master select.
- apb_penable  out  1  APB master enable.
- apb_pready  in  1  APB ready.
- apb_prdata  in  DWIDTH  APB read data.
- apb_pslverr  in  1  APB slave error.
- host_req  in  1  host pass-through request; held until host_ack.
- host_addr  in  AWIDTH  host access address.
- host_wdata  in  DWIDTH  host write data.
- host_write  in  1  1 = write, 0 = read.
- host_ack  out  1  one-cycle pulse when the host transfer completes.
- host_rdata  out  DWIDTH  read data; valid while host_ack is high.
- host_err  out  1  pslverr of the host transfer; valid with host_ack.

Behaviour:
- Single clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - All APB outputs are 0.
  - phy_reset_n = 0 and phy_p00_reset_n = 0.
  - init_done, init_err, host_ack, host_err are 0; host_rdata is 0.
- A reset asserted mid-operation aborts any APB transfer. psel and penable drop on the next edge, and both PHY resets reassert.
- States: IDLE(0), I_SETUP(1), I_ACCESS(2), WAIT_UC(3), WAIT_DLY(4), DONE(5), H_SETUP(6), ERR(7).
- IDLE:
  - start=1 moves to I_SETUP.
  - paddr=INIT_ADDR, pwdata=INIT_DATA, pwrite=1 and psel=1 are all registered on the same edge.
- I_SETUP: next edge sets penable=1 and moves to I_ACCESS.
- I_ACCESS:
  - Stays while pready=0; there is no timeout on pready.
  - On pready=1 with pslverr=0: next edge clears psel, penable, paddr, pwdata and pwrite to 0, clears the timeout counter, and moves to WAIT_UC.
  - On pready=1 with pslverr=1: same bus clear, but moves to ERR.
- WAIT_UC:
  - Samples uc_init_complete as a level; if it is already high on entry, the state leaves after one cycle.
  - A 16-bit counter increments every cycle while uc_init_complete is low.
  - When the counter reaches UC_TIMEOUT-1 while uc_init_complete is still low, the state moves to ERR.
  - uc_init_complete=1 loads the delay counter with 0 and moves to WAIT_DLY.
- WAIT_DLY:
  - An 8-bit counter increments each cycle.
  - At count RST_DLY-1, the next edge sets phy_reset_n=1, phy_p00_reset_n=1 and init_done=1, and moves to DONE.
  - Net effect: the resets rise exactly RST_DLY+1 cycles after the WAIT_UC cycle that sampled uc_init_complete=1.
  - uc_init_complete dropping during WAIT_DLY is ignored.
- DONE:
  - start is ignored; re-init requires rst.
  - host_req=1 registers host_addr, host_wdata and host_write with psel=1, and moves to H_SETUP.
- H_SETUP: next edge sets penable=1 and moves to the host access phase (encoded as seq_state 6, sub-phase flag).
- Host access phase:
  - On pready=1: host_ack=1 for one cycle, host_rdata=apb_prdata (0 for writes), host_err=pslverr.
  - The APB bus clears and the state returns to DONE. Back-to-back host transfers therefore cost at least 3 cycles each.
- host_req before DONE: held pending with no ack. It is served on the first DONE cycle.
- ERR:
  - init_err=1; PHY resets stay asserted.
  - host_req is acked immediately with host_err=1 and no APB cycle.
  - Exit only via rst.
- Only one APB transfer is ever outstanding. psel never drops without pready, except on rst.

Optional Feature:
- Macro PCIE_PHY_INIT_READBACK_EN.
- Defined:
  - After a successful init write, the block issues an APB read of INIT_ADDR (I_SETUP/I_ACCESS again with pwrite=0).
  - The block compares prdata to INIT_DATA; mismatch or pslverr moves to ERR, match moves to WAIT_UC.
  - The timeout counter starts only after the readback completes.
- Undefined: a single write, then straight to WAIT_UC as described above.

Decomposition:
- Package pcie_phy_init_pkg holds:
  - the state enum and its 3-bit encodings;
  - default AWIDTH, DWIDTH, INIT_ADDR and INIT_DATA constants.
- One sub-module, pcie_phy_apb_master: the two-phase setup/access engine with pready wait.
  - Interface: req, addr, wdata, write, ack, rdata, err.
  - Shared by the init path and the host path.
  - A mux selects the request source.

Test Plan:
- pready tied 1, start at cycle 10:
  - psel=1 at 11, penable=1 at 12, write to 0x30068 with 0x1000_0000.
  - uc_init_complete rises at cycle 40, RST_DLY=20 -> phy_reset_n and phy_p00_reset_n rise at cycle 61; init_done=1.
- pready held 0 for 7 cycles in I_ACCESS -> psel and penable stay stable, with paddr=0x30068 held the whole time.
- uc_init_complete never asserts, UC_TIMEOUT=100 -> ERR at the 100th WAIT_UC cycle; init_err=1; resets stay 0; a later host_req is acked with host_err=1.
- pslverr=1 on the init write -> ERR; no reset release.
- host_req asserted at cycle 5 (before start) with a read of 0x00010 -> no ack until DONE; then host_ack with host_rdata equal to the model value.
- rst pulsed in WAIT_DLY, count 15 -> next cycle IDLE with resets 0; a fresh start completes a full sequence.

Source files
------------

// File: rtl/pcie_phy_init_pkg.sv
// PHY bring-up sequencer shared types: state encodings and default bus/init constants.
// No logic; imported by the sequencer and its APB master.
// No flow control of its own.
package pcie_phy_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_I_SETUP  = 3'd1,
        ST_I_ACCESS = 3'd2,
        ST_WAIT_UC  = 3'd3,
        ST_WAIT_DLY = 3'd4,
        ST_DONE     = 3'd5,
        ST_H_SETUP  = 3'd6,
        ST_ERR      = 3'd7
    } seq_state_e;

    localparam int          PHY_AWIDTH    = 18;
    localparam int          PHY_DWIDTH    = 32;
    localparam logic [17:0] PHY_INIT_ADDR = 18'h3_0068;
    localparam logic [31:0] PHY_INIT_DATA = 32'h1000_0000;

endpackage

// File: rtl/pcie_phy_apb_master.sv
// Two-phase APB master: one transfer at a time, request accepted when idle or on completion.
// Latency: psel one edge after req, penable one edge later, ack combinational on pready.
// Backpressure: access phase holds indefinitely while pready is low.
module pcie_phy_apb_master #(
    parameter int AWIDTH = 18,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              write,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              err,
    output logic [AWIDTH-1:0] apb_paddr,
    output logic [DWIDTH-1:0] apb_pwdata,
    output logic              apb_pwrite,
    output logic              apb_psel,
    output logic              apb_penable,
    input  logic              apb_pready,
    input  logic [DWIDTH-1:0] apb_prdata,
    input  logic              apb_pslverr
);

    // Completion is combinational so the owner can change state on the same edge the bus clears.
    assign ack   = apb_psel & apb_penable & apb_pready;
    assign rdata = apb_prdata;
    assign err   = apb_pslverr;

    always_ff @(posedge clk) begin
        if (rst) begin
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            apb_pwrite  <= 1'b0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
        end else if (req && (!apb_psel || ack)) begin
            apb_paddr   <= addr;
            apb_pwdata  <= wdata;
            apb_pwrite  <= write;
            apb_psel    <= 1'b1;
            apb_penable <= 1'b0;
        end else if (ack) begin
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            apb_pwrite  <= 1'b0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
        end else if (apb_psel) begin
            apb_penable <= 1'b1;
        end
    end

endmodule

// File: rtl/pcie_phy_init_seq.sv
// PHY bring-up: init APB write, wait uC done, settle delay, release resets, then host APB pass-through.
// Latency: psel one edge after start; resets rise RST_DLY+1 cycles after uc_init_complete is seen.
// Backpressure: waits on pready without timeout; host_req held until host_ack. PCIE_PHY_INIT_READBACK_EN adds a verify read.
module pcie_phy_init_seq
    import pcie_phy_init_pkg::*;
#(
    parameter int                AWIDTH     = PHY_AWIDTH,
    parameter int                DWIDTH     = PHY_DWIDTH,
    parameter logic [AWIDTH-1:0] INIT_ADDR  = PHY_INIT_ADDR,
    parameter logic [DWIDTH-1:0] INIT_DATA  = PHY_INIT_DATA,
    parameter int                RST_DLY    = 20,
    parameter int                UC_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              uc_init_complete,
    output logic              phy_reset_n,
    output logic              phy_p00_reset_n,
    output logic              init_done,
    output logic              init_err,
    output logic [2:0]        seq_state,
    output logic [AWIDTH-1:0] apb_paddr,
    output logic [DWIDTH-1:0] apb_pwdata,
    output logic              apb_pwrite,
    output logic              apb_psel,
    output logic              apb_penable,
    input  logic              apb_pready,
    input  logic [DWIDTH-1:0] apb_prdata,
    input  logic              apb_pslverr,
    input  logic              host_req,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    input  logic              host_write,
    output logic              host_ack,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_err
);

    localparam logic [15:0] UC_LAST  = 16'(UC_TIMEOUT - 1);
    localparam logic [7:0]  DLY_LAST = 8'(RST_DLY - 1);

    seq_state_e        state;
    logic [15:0]       uc_cnt;
    logic [7:0]        dly_cnt;

    logic              m_req;
    logic [AWIDTH-1:0] m_addr;
    logic [DWIDTH-1:0] m_wdata;
    logic              m_write;
    logic              m_ack;
    logic [DWIDTH-1:0] m_rdata;
    logic              m_err;
    logic              init_launch;
    logic              host_launch;

    assign host_launch = (state == ST_DONE) && host_req;

`ifdef PCIE_PHY_INIT_READBACK_EN
    logic rb_phase;
    logic rb_launch;

    // The verify read goes out on the edge the write completes, keeping psel high across both.
    assign rb_launch   = (state == ST_I_ACCESS) && m_ack && !m_err && !rb_phase;
    assign init_launch = ((state == ST_IDLE) && start) || rb_launch;
    assign m_write     = host_launch ? host_write : !rb_launch;
    assign m_wdata     = host_launch ? host_wdata : (rb_launch ? '0 : INIT_DATA);
`else
    assign init_launch = (state == ST_IDLE) && start;
    assign m_write     = host_launch ? host_write : 1'b1;
    assign m_wdata     = host_launch ? host_wdata : INIT_DATA;
`endif

    assign m_req     = init_launch || host_launch;
    assign m_addr    = host_launch ? host_addr : INIT_ADDR;
    assign seq_state = state;

    pcie_phy_apb_master #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_apb_master (
        .clk         (clk),
        .rst         (rst),
        .req         (m_req),
        .addr        (m_addr),
        .wdata       (m_wdata),
        .write       (m_write),
        .ack         (m_ack),
        .rdata       (m_rdata),
        .err         (m_err),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_pwrite  (apb_pwrite),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pready  (apb_pready),
        .apb_prdata  (apb_prdata),
        .apb_pslverr (apb_pslverr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            uc_cnt          <= '0;
            dly_cnt         <= '0;
            phy_reset_n     <= 1'b0;
            phy_p00_reset_n <= 1'b0;
            init_done       <= 1'b0;
            init_err        <= 1'b0;
            host_ack        <= 1'b0;
            host_rdata      <= '0;
            host_err        <= 1'b0;
`ifdef PCIE_PHY_INIT_READBACK_EN
            rb_phase        <= 1'b0;
`endif
        end else begin
            host_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_I_SETUP;
`ifdef PCIE_PHY_INIT_READBACK_EN
                        rb_phase <= 1'b0;
`endif
                    end
                end
                ST_I_SETUP: state <= ST_I_ACCESS;
                ST_I_ACCESS: begin
                    if (m_ack) begin
`ifdef PCIE_PHY_INIT_READBACK_EN
                        if (m_err || (rb_phase && (m_rdata != INIT_DATA))) begin
                            state    <= ST_ERR;
                            init_err <= 1'b1;
                        end else if (!rb_phase) begin
                            state    <= ST_I_SETUP;
                            rb_phase <= 1'b1;
                        end else begin
                            state  <= ST_WAIT_UC;
                            uc_cnt <= '0;
                        end
`else
                        if (m_err) begin
                            state    <= ST_ERR;
                            init_err <= 1'b1;
                        end else begin
                            state  <= ST_WAIT_UC;
                            uc_cnt <= '0;
                        end
`endif
                    end
                end
                ST_WAIT_UC: begin
                    if (uc_init_complete) begin
                        state   <= ST_WAIT_DLY;
                        dly_cnt <= '0;
                    end else if (uc_cnt == UC_LAST) begin
                        state    <= ST_ERR;
                        init_err <= 1'b1;
                    end else begin
                        uc_cnt <= uc_cnt + 16'd1;
                    end
                end
                // uc_init_complete is deliberately not re-checked once the delay has started.
                ST_WAIT_DLY: begin
                    if (dly_cnt == DLY_LAST) begin
                        state           <= ST_DONE;
                        phy_reset_n     <= 1'b1;
                        phy_p00_reset_n <= 1'b1;
                        init_done       <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (host_req) begin
                        state <= ST_H_SETUP;
                    end
                end
                // Covers both host setup and access; apb_penable is the sub-phase flag.
                ST_H_SETUP: begin
                    if (m_ack) begin
                        state      <= ST_DONE;
                        host_ack   <= 1'b1;
                        host_rdata <= apb_pwrite ? '0 : m_rdata;
                        host_err   <= m_err;
                    end
                end
                ST_ERR: begin
                    init_err <= 1'b1;
                    if (host_req && !host_ack) begin
                        host_ack   <= 1'b1;
                        host_rdata <= '0;
                        host_err   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_phy_init_seq.sv
// Directed bench for pcie_phy_init_seq with a small APB slave model.
module tb_pcie_phy_init_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        uc_init_complete;
    logic        phy_reset_n;
    logic        phy_p00_reset_n;
    logic        init_done;
    logic        init_err;
    logic [2:0]  seq_state;
    logic [17:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic        apb_pwrite;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pready;
    logic [31:0] apb_prdata;
    logic        apb_pslverr;
    logic        host_req;
    logic [17:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_write;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        host_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] init_reg = 32'h0;

    always #5 clk = ~clk;

    // Slave: the init register reads back what was written, other addresses return a fixed pattern.
    assign apb_prdata = (apb_paddr == 18'h3_0068) ? init_reg : (32'hA5A5_0000 | {14'd0, apb_paddr});
    always @(posedge clk)
        if (apb_psel && apb_penable && apb_pready && apb_pwrite && apb_paddr == 18'h3_0068)
            init_reg <= apb_pwdata;

    pcie_phy_init_seq #(
        .RST_DLY    (20),
        .UC_TIMEOUT (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .uc_init_complete (uc_init_complete),
        .phy_reset_n      (phy_reset_n),
        .phy_p00_reset_n  (phy_p00_reset_n),
        .init_done        (init_done),
        .init_err         (init_err),
        .seq_state        (seq_state),
        .apb_paddr        (apb_paddr),
        .apb_pwdata       (apb_pwdata),
        .apb_pwrite       (apb_pwrite),
        .apb_psel         (apb_psel),
        .apb_penable      (apb_penable),
        .apb_pready       (apb_pready),
        .apb_prdata       (apb_prdata),
        .apb_pslverr      (apb_pslverr),
        .host_req         (host_req),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_write       (host_write),
        .host_ack         (host_ack),
        .host_rdata       (host_rdata),
        .host_err         (host_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; uc_init_complete = 1'b0;
        apb_pready = 1'b1; apb_pslverr = 1'b0;
        host_req = 1'b0; host_addr = '0; host_wdata = '0; host_write = 1'b0;
        tick(); tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; uc_init_complete = 1'b0;
        apb_pready = 1'b1; apb_pslverr = 1'b0;
        host_req = 1'b0; host_addr = '0; host_wdata = '0; host_write = 1'b0;
        tick(); tick();
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", seq_state); end
        checks++; if ({apb_psel, apb_penable, apb_pwrite} !== 3'b000 || apb_paddr !== 18'h0 || apb_pwdata !== 32'h0) begin
            errors++; $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h expected all 0", apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata); end
        checks++; if ({phy_reset_n, phy_p00_reset_n, init_done, init_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {phy_reset_n, phy_p00_reset_n, init_done, init_err}); end
        checks++; if ({host_ack, host_err} !== 2'b00 || host_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_host: got ack=%b err=%b rdata=%h expected 0", host_ack, host_err, host_rdata); end
        rst = 1'b0;
        cyc = 0;
    endtask

    // start at cycle 10, uc at 40, resets rise at 61.
    task automatic test_basic_init();
        do_reset();
        go_to(10); start = 1'b1;
        tick(); start = 1'b0;
        checks++; if (apb_psel !== 1'b1 || apb_penable !== 1'b0 || seq_state !== 3'd1) begin
            errors++; $display("FAIL init_setup: got psel=%b pen=%b state=%0d expected 1 0 1", apb_psel, apb_penable, seq_state); end
        tick();
        checks++; if (apb_psel !== 1'b1 || apb_penable !== 1'b1 || apb_pwrite !== 1'b1 || apb_paddr !== 18'h3_0068 || apb_pwdata !== 32'h1000_0000) begin
            errors++; $display("FAIL init_access: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h expected 1 1 1 30068 10000000", apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata); end
        tick();
        checks++; if (apb_psel !== 1'b0 || apb_penable !== 1'b0 || apb_paddr !== 18'h0 || seq_state !== 3'd3) begin
            errors++; $display("FAIL init_clear: got psel=%b pen=%b paddr=%h state=%0d expected 0 0 0 3", apb_psel, apb_penable, apb_paddr, seq_state); end
        go_to(40); uc_init_complete = 1'b1;
        checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL wait_uc_state: got %0d expected 3", seq_state); end
        go_to(60);
        checks++; if ({phy_reset_n, phy_p00_reset_n, init_done} !== 3'b000 || seq_state !== 3'd4) begin
            errors++; $display("FAIL pre_release: got rst=%b init_done=%b state=%0d expected 00 0 4", {phy_reset_n, phy_p00_reset_n}, init_done, seq_state); end
        tick();
        checks++; if ({phy_reset_n, phy_p00_reset_n, init_done} !== 3'b111 || seq_state !== 3'd5) begin
            errors++; $display("FAIL release_61: got rst=%b init_done=%b state=%0d expected 11 1 5", {phy_reset_n, phy_p00_reset_n}, init_done, seq_state); end
    endtask

    // Continues from DONE at cycle 61: write then read, acks 3 cycles apart.
    task automatic test_back_to_back();
        go_to(62);
        host_req = 1'b1; host_addr = 18'h0_0020; host_wdata = 32'hDEAD_BEEF; host_write = 1'b1;
        tick();
        checks++; if (apb_psel !== 1'b1 || apb_paddr !== 18'h0_0020 || apb_pwdata !== 32'hDEAD_BEEF || apb_pwrite !== 1'b1 || seq_state !== 3'd6) begin
            errors++; $display("FAIL host_wr_setup: got psel=%b paddr=%h pwdata=%h pwr=%b state=%0d expected 1 00020 deadbeef 1 6", apb_psel, apb_paddr, apb_pwdata, apb_pwrite, seq_state); end
        go_to(65);
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'h0 || host_err !== 1'b0 || seq_state !== 3'd5) begin
            errors++; $display("FAIL host_wr_ack: got ack=%b rdata=%h err=%b state=%0d expected 1 0 0 5", host_ack, host_rdata, host_err, seq_state); end
        host_addr = 18'h0_0024; host_wdata = 32'h0; host_write = 1'b0;
        tick();
        checks++; if (host_ack !== 1'b0 || apb_paddr !== 18'h0_0024 || apb_pwrite !== 1'b0) begin
            errors++; $display("FAIL host_rd_setup: got ack=%b paddr=%h pwr=%b expected 0 00024 0", host_ack, apb_paddr, apb_pwrite); end
        go_to(68);
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'hA5A5_0024 || host_err !== 1'b0) begin
            errors++; $display("FAIL host_rd_ack: got ack=%b rdata=%h err=%b expected 1 a5a50024 0", host_ack, host_rdata, host_err); end
        host_req = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        checks++; if (host_ack !== 1'b0 || apb_psel !== 1'b0 || seq_state !== 3'd5) begin
            errors++; $display("FAIL done_idle: got ack=%b psel=%b state=%0d expected 0 0 5", host_ack, apb_psel, seq_state); end
    endtask

    task automatic test_pready_wait();
        int bad = 0;
        do_reset();
        apb_pready = 1'b0;
        go_to(2); start = 1'b1;
        tick(); start = 1'b0;
        go_to(4);
        for (int i = 0; i < 7; i++) begin
            if (apb_psel !== 1'b1 || apb_penable !== 1'b1 || apb_paddr !== 18'h3_0068 || seq_state !== 3'd2) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pready_hold: got %0d unstable cycles expected 0", bad); end
        apb_pready = 1'b1;
        checks++; if (apb_psel !== 1'b1 || apb_penable !== 1'b1) begin
            errors++; $display("FAIL pready_still: got psel=%b pen=%b expected 1 1", apb_psel, apb_penable); end
        tick();
        checks++; if (apb_psel !== 1'b0 || seq_state !== 3'd3) begin
            errors++; $display("FAIL pready_done: got psel=%b state=%0d expected 0 3", apb_psel, seq_state); end
    endtask

    // WAIT_UC spans cycles 4..103 with UC_TIMEOUT=100, so ERR shows at 104.
    task automatic test_timeout();
        do_reset();
        go_to(1); start = 1'b1;
        tick(); start = 1'b0;
        go_to(103);
        checks++; if (seq_state !== 3'd3 || init_err !== 1'b0) begin
            errors++; $display("FAIL timeout_last_wait: got state=%0d err=%b expected 3 0", seq_state, init_err); end
        tick();
        checks++; if (seq_state !== 3'd7 || init_err !== 1'b1 || phy_reset_n !== 1'b0 || phy_p00_reset_n !== 1'b0) begin
            errors++; $display("FAIL timeout_err: got state=%0d err=%b rst=%b%b expected 7 1 00", seq_state, init_err, phy_reset_n, phy_p00_reset_n); end
        go_to(106); host_req = 1'b1; host_addr = 18'h0_0010; host_write = 1'b0;
        tick(); host_req = 1'b0;
        checks++; if (host_ack !== 1'b1 || host_err !== 1'b1 || apb_psel !== 1'b0) begin
            errors++; $display("FAIL err_host_ack: got ack=%b err=%b psel=%b expected 1 1 0", host_ack, host_err, apb_psel); end
        start = 1'b1; uc_init_complete = 1'b1;
        tick(); start = 1'b0;
        tick();
        checks++; if (host_ack !== 1'b0 || seq_state !== 3'd7 || init_err !== 1'b1 || phy_reset_n !== 1'b0) begin
            errors++; $display("FAIL err_sticky: got ack=%b state=%0d err=%b rst=%b expected 0 7 1 0", host_ack, seq_state, init_err, phy_reset_n); end
    endtask

    task automatic test_slverr();
        do_reset();
        apb_pslverr = 1'b1;
        go_to(1); start = 1'b1;
        tick(); start = 1'b0;
        go_to(4);
        apb_pslverr = 1'b0; uc_init_complete = 1'b1;
        checks++; if (seq_state !== 3'd7 || init_err !== 1'b1 || apb_psel !== 1'b0) begin
            errors++; $display("FAIL slverr_err: got state=%0d err=%b psel=%b expected 7 1 0", seq_state, init_err, apb_psel); end
        go_to(40);
        checks++; if (phy_reset_n !== 1'b0 || phy_p00_reset_n !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL slverr_no_release: got rst=%b%b done=%b expected 00 0", phy_reset_n, phy_p00_reset_n, init_done); end
    endtask

    task automatic test_host_early();
        int early = 0;
        do_reset();
        go_to(5); host_req = 1'b1; host_addr = 18'h0_0010; host_write = 1'b0; host_wdata = '0;
        go_to(10); start = 1'b1;
        tick(); start = 1'b0;
        while (cyc < 61) begin
            if (cyc == 40) uc_init_complete = 1'b1;
            if (host_ack !== 1'b0) early++;
            tick();
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL host_early_ack: got %0d acks before DONE expected 0", early); end
        tick();
        checks++; if (apb_psel !== 1'b1 || apb_paddr !== 18'h0_0010 || apb_pwrite !== 1'b0 || seq_state !== 3'd6) begin
            errors++; $display("FAIL host_early_setup: got psel=%b paddr=%h pwr=%b state=%0d expected 1 00010 0 6", apb_psel, apb_paddr, apb_pwrite, seq_state); end
        go_to(64);
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'hA5A5_0010 || host_err !== 1'b0) begin
            errors++; $display("FAIL host_early_ack_data: got ack=%b rdata=%h err=%b expected 1 a5a50010 0", host_ack, host_rdata, host_err); end
        host_req = 1'b0;
    endtask

    // uc seen at cycle 4, delay count 15 at cycle 20; rst sampled at edge 21.
    task automatic test_rst_mid();
        do_reset();
        go_to(1); start = 1'b1;
        tick(); start = 1'b0;
        go_to(4); uc_init_complete = 1'b1;
        go_to(20);
        checks++; if (seq_state !== 3'd4 || phy_reset_n !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre: got state=%0d rst_n=%b expected 4 0", seq_state, phy_reset_n); end
        rst = 1'b1;
        tick(); rst = 1'b0;
        checks++; if (seq_state !== 3'd0 || phy_reset_n !== 1'b0 || phy_p00_reset_n !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got state=%0d rst=%b%b done=%b expected 0 00 0", seq_state, phy_reset_n, phy_p00_reset_n, init_done); end
        go_to(22); start = 1'b1;
        tick(); start = 1'b0;
        go_to(45);
        checks++; if (phy_reset_n !== 1'b0 || seq_state !== 3'd4) begin
            errors++; $display("FAIL rerun_pre: got rst_n=%b state=%0d expected 0 4", phy_reset_n, seq_state); end
        tick();
        checks++; if (phy_reset_n !== 1'b1 || phy_p00_reset_n !== 1'b1 || init_done !== 1'b1 || seq_state !== 3'd5) begin
            errors++; $display("FAIL rerun_release: got rst=%b%b done=%b state=%0d expected 11 1 5", phy_reset_n, phy_p00_reset_n, init_done, seq_state); end
    endtask

    initial begin
        test_reset();
        test_basic_init();
        test_back_to_back();
        test_pready_wait();
        test_timeout();
        test_slverr();
        test_host_early();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
